// File: rtl/bitscan_pkg.sv
// Shared types and helpers for the bitscan encoder: FSM state enum and index-width function.
package bitscan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bitscan_encoder_prio_enc.sv
// Combinational priority encoder: index of the first set bit scanning from bit 0
// (MSB_FIRST=0) or from bit N-1 (MSB_FIRST=1), plus an any-bit-set flag.
module prio_enc
    import bitscan_pkg::*;
#(
    parameter int N         = 8,
    parameter int W         = idx_width(N),
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic [N-1:0] i_vec,
    output logic [W-1:0] o_idx,
    output logic         o_any
);

    always_comb begin
        o_idx = '0;
        o_any = |i_vec;
        // Scan toward the preferred end so the last match wins.
        if (MSB_FIRST) begin
            for (int i = 0; i < N; i++) begin
                if (i_vec[i]) o_idx = W'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (i_vec[i]) o_idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/bitscan_encoder.sv
// Sequential bit-scan encoder: accepts an N-bit vector and emits one set-bit index per beat.
// Define BITSCAN_MSB_FIRST_EN to emit highest set bit first (default: lowest first).
module bitscan_encoder
    import bitscan_pkg::*;
#(
    parameter int N = 8,
    parameter int W = idx_width(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_vec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_last,
    output logic         out_none,
    output logic [W:0]   out_seq
);

`ifdef BITSCAN_MSB_FIRST_EN
    localparam bit MSB_FIRST = 1'b1;
`else
    localparam bit MSB_FIRST = 1'b0;
`endif

    localparam logic [N-1:0] ONE = N'(1);

    state_t       r_state;
    logic [N-1:0] r_pend;
    logic [W:0]   r_seq;
    logic         r_zflag;

    logic [W-1:0] w_idx;
    logic         w_any;
    logic         w_last;
    logic [N-1:0] w_clr;

    prio_enc #(
        .N         (N),
        .W         (W),
        .MSB_FIRST (MSB_FIRST)
    ) u_prio_enc (
        .i_vec (r_pend),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // Every output is a function of registers only; in_ready also gates on rst.
    assign out_idx   = w_any ? w_idx : '0;
    assign w_last    = (r_pend & (r_pend - ONE)) == '0;
    assign w_clr     = ONE << out_idx;
    assign out_last  = w_last;
    assign out_none  = r_zflag;
    assign out_seq   = r_seq;
    assign out_valid = (r_state == EMIT);
    assign in_ready  = (r_state == IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_pend  <= '0;
            r_seq   <= '0;
            r_zflag <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_pend  <= in_vec;
                        r_seq   <= '0;
                        r_zflag <= (in_vec == '0);
                        r_state <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        r_pend <= r_pend & ~w_clr;
                        r_seq  <= r_seq + 1'b1;
                        if (w_last) r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bitscan_encoder.sv
// Directed self-checking bench for bitscan_encoder (N=8); expectations follow BITSCAN_MSB_FIRST_EN.
module tb_bitscan_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_vec;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_idx;
    logic       out_last;
    logic       out_none;
    logic [3:0] out_seq;

    int checks = 0;
    int errors = 0;

    // {valid, none, last, idx[2:0], seq[3:0]}
    logic [9:0] got;
    assign got = {out_valid, out_none, out_last, out_idx, out_seq};

`ifdef BITSCAN_MSB_FIRST_EN
    localparam bit MSB = 1'b1;
    int exp_a4 [3] = '{7, 5, 2};
    int exp_81 [2] = '{7, 0};
`else
    localparam bit MSB = 1'b0;
    int exp_a4 [3] = '{2, 5, 7};
    int exp_81 [2] = '{0, 7};
`endif

    always #5 clk = ~clk;

    bitscan_encoder #(.N(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_none  (out_none),
        .out_seq   (out_seq)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] v);
        in_valid = 1'b1;
        in_vec   = v;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({out_valid, in_ready} !== 2'b00) begin
                errors++;
                $display("FAIL reset_hold cyc %0d got valid/ready %b exp 00", i, {out_valid, in_ready});
            end
            step();
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL reset_release got valid/ready %b exp 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send(8'b1010_0100);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got !== {1'b1, 1'b0, (i == 2), 3'(exp_a4[i]), 4'(i)}) begin
                errors++;
                $display("FAIL basic beat %0d got %b exp idx %0d seq %0d", i, got, exp_a4[i], i);
            end
            step();
        end
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL basic_idle got valid/ready %b exp 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_zero();
        out_ready = 1'b1;
        send(8'h00);
        checks++;
        if (got !== {1'b1, 1'b1, 1'b1, 3'd0, 4'd0}) begin
            errors++;
            $display("FAIL zero_beat got %b exp 1110000000", got);
        end
        step();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL zero_idle got valid/ready %b exp 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(8'h81);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got !== {1'b1, 1'b0, 1'b0, 3'(exp_81[0]), 4'd0}) begin
                errors++;
                $display("FAIL bp_hold cyc %0d got %b exp idx %0d last 0", i, got, exp_81[0]);
            end
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (got !== {1'b1, 1'b0, (i == 1), 3'(exp_81[i]), 4'(i)}) begin
                errors++;
                $display("FAIL bp_beat %0d got %b exp idx %0d", i, got, exp_81[i]);
            end
            step();
        end
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_idle got valid/ready %b exp 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_back_to_back();
        int e;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_vec    = 8'hFF;
        step();
        in_vec = 8'h10;  // held valid; must be ignored until IDLE
        for (int i = 0; i < 8; i++) begin
            e = MSB ? 7 - i : i;
            checks++;
            if ({in_ready, got} !== {1'b0, 1'b1, 1'b0, (i == 7), 3'(e), 4'(i)}) begin
                errors++;
                $display("FAIL b2b_ff beat %0d got rdy %b %b exp idx %0d seq %0d", i, in_ready, got, e, i);
            end
            step();
        end
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_gap got valid/ready %b exp 01", {out_valid, in_ready});
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (got !== {1'b1, 1'b0, 1'b1, 3'd4, 4'd0}) begin
            errors++;
            $display("FAIL b2b_second got %b exp 1011000000", got);
        end
        step();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_idle got valid/ready %b exp 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        send(8'h0E);
        checks++;
        if (got !== {1'b1, 1'b0, 1'b0, (MSB ? 3'd3 : 3'd1), 4'd0}) begin
            errors++;
            $display("FAIL mid_first got %b", got);
        end
        step();
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b00) begin
            errors++;
            $display("FAIL mid_async got valid/ready %b exp 00", {out_valid, in_ready});
        end
        step();
        rst = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL mid_release got valid/ready %b exp 01", {out_valid, in_ready});
        end
        send(8'h02);
        checks++;
        if (got !== {1'b1, 1'b0, 1'b1, 3'd1, 4'd0}) begin
            errors++;
            $display("FAIL mid_new got %b exp 1010010000", got);
        end
        step();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL mid_idle got valid/ready %b exp 01", {out_valid, in_ready});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
